prog_mem: RTL and testbench

Program memory responder for the 16-bit `mproc` datapath. It holds 128 x 16-bit words addressed by the processor's 7-bit `addr` and answers with the instruction word on the processor's `d_in`. An external loader fills it through a valid/ready stream. The block also owns the processor's reset, keeping the CPU in reset until a complete program has been loaded.

---
 rtl/prog_mem.sv | 110 +++++++++++
 tb/tb_prog_mem.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem.sv
// Program memory for the mproc datapath: 128 x 16-bit words, filled by a valid/ready loader.
// It holds the CPU in reset until a complete program has been cleared, loaded and released.
module prog_mem (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [15:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic [6:0]  cpu_addr,
  output logic [15:0] cpu_data,
  output logic        cpu_reset,
  output logic        loaded,
  output logic        err,
  output logic [6:0]  wr_ptr
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    LOAD    = 3'd2,
    RELEASE = 3'd3,
    RUN     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  wr_ptr_q, wr_ptr_d;
  logic        err_q, err_d;
  logic        loaded_q, loaded_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        mem_we;
  logic [15:0] mem_wdata;

  logic [15:0] mem [128];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= 7'd0;
      err_q       <= 1'b0;
      loaded_q    <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      err_q       <= err_d;
      loaded_q    <= loaded_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

  // Array contents survive reset; only the control state above is cleared.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= mem_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_wdata = 16'h0000;
    if (ld_start) begin
      // A restart wins over everything, including a word offered this cycle.
      state_d  = CLEAR;
      wr_ptr_d = 7'd0;
      err_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        CLEAR: begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 7'd1;
          if (wr_ptr_q == 7'd127) begin
            state_d = LOAD;
          end
        end
        LOAD: begin
          if (ld_valid) begin
            mem_we    = 1'b1;
            mem_wdata = ld_data;
            wr_ptr_d  = wr_ptr_q + 7'd1;
            if (ld_last) begin
              state_d = RELEASE;
            end else if (wr_ptr_q == 7'd127) begin
              err_d   = 1'b1;
              state_d = RELEASE;
            end
          end
        end
        RELEASE: state_d = RUN;
        RUN:     ;
        default: state_d = IDLE;
      endcase
    end
    loaded_d    = (state_d == RUN);
    cpu_reset_d = (state_d != RUN);
  end

  assign ld_ready  = (state_q == LOAD) && !ld_start;
  assign cpu_data  = (state_q == RUN) ? mem[cpu_addr] : 16'h0000;
  assign cpu_reset = cpu_reset_q;
  assign loaded    = loaded_q;
  assign err       = err_q;
  assign wr_ptr    = wr_ptr_q;

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: reset, short load, backpressure, overflow, restart and reset mid-operation.
module tb_prog_mem;

  logic        clk;
  logic        reset;
  logic        ld_start;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic [6:0]  cpu_addr;
  logic [15:0] cpu_data;
  logic        cpu_reset;
  logic        loaded;
  logic        err;
  logic [6:0]  wr_ptr;

  int checks;
  int failures;

  prog_mem dut (
    .clk       (clk),
    .reset     (reset),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .cpu_reset (cpu_reset),
    .loaded    (loaded),
    .err       (err),
    .wr_ptr    (wr_ptr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [6:0] a, input logic [15:0] exp);
    cpu_addr = a;
    #1;
    chk(tag, {16'h0, cpu_data}, {16'h0, exp});
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
  endtask

  task automatic wait_clear();
    repeat (64) step();
    chk("clear_mid_ptr", {25'h0, wr_ptr}, 32'd64);
    chk("clear_mid_ready", {31'h0, ld_ready}, 32'd0);
    repeat (64) step();
    chk("load_ready", {31'h0, ld_ready}, 32'd1);
    chk("load_ptr", {25'h0, wr_ptr}, 32'd0);
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = 16'h0000;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_data  = 16'h0000;
    ld_last  = 1'b0;
    cpu_addr = 7'd0;

    // Reset values
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_cpu_reset", {31'h0, cpu_reset}, 32'd1);
    chk("rst_loaded", {31'h0, loaded}, 32'd0);
    chk("rst_ready", {31'h0, ld_ready}, 32'd0);
    chk("rst_err", {31'h0, err}, 32'd0);
    chk("rst_ptr", {25'h0, wr_ptr}, 32'd0);
    rd("rst_data0", 7'd0, 16'h0000);
    rd("rst_data77", 7'd77, 16'h0000);
    ld_valid = 1'b1;
    ld_data  = 16'hBEEF;
    step();
    step();
    ld_valid = 1'b0;
    chk("idle_ignore_ptr", {25'h0, wr_ptr}, 32'd0);
    chk("idle_ready", {31'h0, ld_ready}, 32'd0);

    // Short load
    start_load();
    chk("start_ptr", {25'h0, wr_ptr}, 32'd0);
    wait_clear();
    send(16'h1234, 1'b0);
    send(16'hABCD, 1'b0);
    send(16'h00FF, 1'b1);
    chk("rel_cpu_reset", {31'h0, cpu_reset}, 32'd1);
    chk("rel_ready", {31'h0, ld_ready}, 32'd0);
    chk("rel_loaded", {31'h0, loaded}, 32'd0);
    chk("rel_ptr", {25'h0, wr_ptr}, 32'd3);
    rd("rel_data0", 7'd0, 16'h0000);
    step();
    chk("run_cpu_reset", {31'h0, cpu_reset}, 32'd0);
    chk("run_loaded", {31'h0, loaded}, 32'd1);
    chk("run_err", {31'h0, err}, 32'd0);
    rd("short_d0", 7'd0, 16'h1234);
    rd("short_d1", 7'd1, 16'hABCD);
    rd("short_d2", 7'd2, 16'h00FF);
    rd("short_d3", 7'd3, 16'h0000);

    // Backpressure, entered by a restart from RUN
    start_load();
    chk("restart_cpu_reset", {31'h0, cpu_reset}, 32'd1);
    chk("restart_loaded", {31'h0, loaded}, 32'd0);
    wait_clear();
    send(16'h1234, 1'b0);
    repeat (5) step();
    chk("bp_ptr_a", {25'h0, wr_ptr}, 32'd1);
    repeat (5) step();
    chk("bp_ptr_b", {25'h0, wr_ptr}, 32'd1);
    chk("bp_ready", {31'h0, ld_ready}, 32'd1);
    send(16'hABCD, 1'b0);
    send(16'h00FF, 1'b1);
    step();
    chk("bp_loaded", {31'h0, loaded}, 32'd1);
    chk("bp_ptr_end", {25'h0, wr_ptr}, 32'd3);
    rd("bp_d0", 7'd0, 16'h1234);
    rd("bp_d1", 7'd1, 16'hABCD);
    rd("bp_d2", 7'd2, 16'h00FF);
    rd("bp_d3", 7'd3, 16'h0000);

    // Overflow
    start_load();
    wait_clear();
    for (int i = 0; i < 128; i++) begin
      send(16'(i), 1'b0);
    end
    chk("ovf_err", {31'h0, err}, 32'd1);
    chk("ovf_ptr", {25'h0, wr_ptr}, 32'd0);
    chk("ovf_ready", {31'h0, ld_ready}, 32'd0);
    ld_valid = 1'b1;
    ld_data  = 16'hFFFF;
    step();
    chk("ovf_loaded", {31'h0, loaded}, 32'd1);
    chk("ovf_run_err", {31'h0, err}, 32'd1);
    step();
    ld_valid = 1'b0;
    chk("ovf_run_ptr", {25'h0, wr_ptr}, 32'd0);
    rd("ovf_d127", 7'd127, 16'h007F);
    rd("ovf_d0", 7'd0, 16'h0000);
    rd("ovf_d5", 7'd5, 16'h0005);

    // Restart mid-load with a word offered alongside ld_start
    start_load();
    chk("restart_err_clr", {31'h0, err}, 32'd0);
    wait_clear();
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 16'h3333;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    chk("drop_ptr", {25'h0, wr_ptr}, 32'd0);
    chk("drop_ready", {31'h0, ld_ready}, 32'd0);
    wait_clear();
    send(16'h5555, 1'b1);
    step();
    chk("reload_loaded", {31'h0, loaded}, 32'd1);
    chk("reload_ptr", {25'h0, wr_ptr}, 32'd1);
    rd("reload_d0", 7'd0, 16'h5555);
    rd("reload_d1", 7'd1, 16'h0000);
    rd("reload_d2", 7'd2, 16'h0000);
    rd("reload_d127", 7'd127, 16'h0000);

    // Reset during CLEAR
    start_load();
    repeat (30) step();
    chk("pre_rst_ptr", {25'h0, wr_ptr}, 32'd30);
    reset = 1'b1;
    #1;
    chk("rst_clear_ptr", {25'h0, wr_ptr}, 32'd0);
    chk("rst_clear_cpu_reset", {31'h0, cpu_reset}, 32'd1);
    step();
    reset = 1'b0;
    step();
    chk("rst_clear_idle_ptr", {25'h0, wr_ptr}, 32'd0);
    chk("rst_clear_idle_ready", {31'h0, ld_ready}, 32'd0);
    start_load();
    wait_clear();
    send(16'h7777, 1'b1);
    step();
    chk("run2_cpu_reset", {31'h0, cpu_reset}, 32'd0);
    rd("run2_d0", 7'd0, 16'h7777);

    // Reset during RUN takes effect without a clock edge
    reset = 1'b1;
    #1;
    chk("rst_run_cpu_reset", {31'h0, cpu_reset}, 32'd1);
    chk("rst_run_loaded", {31'h0, loaded}, 32'd0);
    chk("rst_run_ptr", {25'h0, wr_ptr}, 32'd0);
    rd("rst_run_d0", 7'd0, 16'h0000);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_cpu_reset", {31'h0, cpu_reset}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
